alu_pipe: RTL and testbench

Parametrised successor to the 5-bit ALU. Adds a valid/ready handshake on input and output, a unified 4-bit opcode, and a multi-cycle iterative signed multiply. It also adds an overflow/saturation mode and a saturating error counter. It sits between the operand sequencer and the result consumer, one transaction at a time with output back-pressure.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_pipe_if.sv | 12 +
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/alu_pipe.sv | 90 +++++++++
 tb/tb_alu_pipe.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types shared by alu_pipe and its helpers
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_XNOR, OP_NAND, OP_DEC,
    OP_INC2, OP_MUL, OP_ILL10, OP_ILL11, OP_ILL12, OP_ILL13, OP_ILL14, OP_ILL15
  } op_e;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;
  localparam logic [3:0] OP_MAX_LEGAL = 4'd9;
  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_MAX_LEGAL;
  endfunction
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bus plus error-counter sideband
interface alu_pipe_if #(parameter int WIDTH = 5, parameter int ERRW = 8);
  logic in_valid, in_ready, out_valid, out_ready, error, overflow, err_clr;
  logic signed [WIDTH-1:0] a, b;
  logic [3:0] op;
  logic signed [WIDTH:0] c;
  logic [ERRW-1:0] err_count;
  modport slave (input in_valid, a, b, op, out_ready, err_clr,
                 output in_ready, out_valid, c, error, overflow, err_count);
  modport master (output in_valid, a, b, op, out_ready, err_clr,
                  input in_ready, out_valid, c, error, overflow, err_count);
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add signed multiplier on magnitudes, one bit per cycle
// done flags the final iteration; p is valid combinationally alongside it.
module alu_mul_iter import alu_pkg::*; #(parameter int WIDTH = 5) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] p
);
  localparam int P = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  logic [P-1:0] acc_q, acc_d, mc_q, mc_d, sum;
  logic [WIDTH-1:0] mp_q, mp_d, au, bu;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, busy_q, busy_d;
  assign au = a;
  assign bu = b;
  assign sum = acc_q + (mp_q[0] ? mc_q : '0);
  assign done = busy_q && cnt_q == CW'(WIDTH - 1);
  assign p = neg_q ? -sum : sum;
  always_comb begin
    acc_d = acc_q;
    mc_d = mc_q;
    mp_d = mp_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    busy_d = busy_q;
    if (start) begin
      acc_d = '0;
      mc_d = {{WIDTH{1'b0}}, au[WIDTH-1] ? -au : au};
      mp_d = bu[WIDTH-1] ? -bu : bu;
      cnt_d = '0;
      neg_d = au[WIDTH-1] ^ bu[WIDTH-1];
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = sum;
      mc_d = mc_q << 1;
      mp_d = mp_q >> 1;
      cnt_d = cnt_q + 1'b1;
      busy_d = !done;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      mc_q <= '0;
      mp_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mc_q <= mc_d;
      mp_q <= mp_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      busy_q <= busy_d;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with iterative MUL, optional saturation and error counter
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = 5,
  parameter int SAT = 0,
  parameter int ERRW = 8
) (
  input logic clk,
  input logic rst,
  alu_pipe_if.slave bus
);
  localparam int R = WIDTH + 1;
  localparam int P = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [R-1:0] MAX_R = {1'b0, {WIDTH{1'b1}}};
  localparam logic [R-1:0] MIN_R = {1'b1, {WIDTH{1'b0}}};
  state_e state_q, state_d;
  op_e op;
  logic signed [R-1:0] c_q, c_d, ax, bx, alu_r, mul_c;
  logic signed [P-1:0] prod;
  logic error_q, error_d, overflow_q, overflow_d;
  logic accept, illegal, bad, is_mul, mul_done, mul_ovf, inc;
  logic [ERRW-1:0] err_count_q, err_count_d;
  assign op = op_e'(bus.op);
  assign illegal = op_illegal(bus.op);
  assign is_mul = op == OP_MUL;
  assign bad = illegal || bus.a == MOST_NEG || bus.b == MOST_NEG;
  assign bus.in_ready = state_q == IDLE || (state_q == HOLD && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign inc = accept && bad;
  assign bus.out_valid = state_q == HOLD;
  assign bus.c = c_q;
  assign bus.error = error_q;
  assign bus.overflow = overflow_q;
  assign bus.err_count = err_count_q;
  assign ax = {bus.a[WIDTH-1], bus.a};
  assign bx = {bus.b[WIDTH-1], bus.b};
  // The product fits WIDTH+1 bits only if all upper bits replicate bit WIDTH
  assign mul_ovf = prod[P-1:WIDTH] != {WIDTH{prod[WIDTH]}};
  assign mul_c = (mul_ovf && SAT != 0) ? (prod[P-1] ? MIN_R : MAX_R) : prod[R-1:0];
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .start(accept && is_mul),
    .a(bus.a), .b(bus.b), .done(mul_done), .p(prod)
  );
  always_comb
    case (op)
      OP_ADD:  alu_r = ax + bx;
      OP_SUB:  alu_r = ax - bx;
      OP_XOR:  alu_r = ax ^ bx;
      OP_AND:  alu_r = ax & bx;
      OP_OR:   alu_r = ax | bx;
      OP_XNOR: alu_r = ~(ax ^ bx);
      OP_NAND: alu_r = ~(ax & bx);
      OP_DEC:  alu_r = ax - R'(1);
      OP_INC2: alu_r = bx + R'(2);
      default: alu_r = c_q;
    endcase
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    error_d = error_q;
    overflow_d = overflow_q;
    err_count_d = bus.err_clr ? ERRW'(inc) : err_count_q + ERRW'(inc && !(&err_count_q));
    if (accept) begin
      error_d = bad;
      overflow_d = 1'b0;
      c_d = is_mul ? c_q : alu_r;
      state_d = is_mul ? BUSY : HOLD;
    end else if (state_q == BUSY && mul_done) begin
      c_d = mul_c;
      overflow_d = mul_ovf;
      state_d = HOLD;
    end else if (state_q == HOLD && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      c_q <= '0;
      error_q <= 1'b0;
      overflow_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      error_q <= error_d;
      overflow_q <= overflow_d;
      err_count_q <= err_count_d;
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe, SAT=0 and SAT=1 instances driven in lockstep
module tb_alu_pipe;
  logic clk, rst;
  int tests, fails;
  alu_pipe_if #(.WIDTH(5), .ERRW(8)) if0 ();
  alu_pipe_if #(.WIDTH(5), .ERRW(8)) if1 ();
  alu_pipe #(.WIDTH(5), .SAT(0), .ERRW(8)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  alu_pipe #(.WIDTH(5), .SAT(1), .ERRW(8)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  assign if1.in_valid = if0.in_valid;
  assign if1.a = if0.a;
  assign if1.b = if0.b;
  assign if1.op = if0.op;
  assign if1.out_ready = if0.out_ready;
  assign if1.err_clr = if0.err_clr;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] op, input int a, input int b);
    if0.in_valid = 1'b1;
    if0.op = op;
    if0.a = 5'(a);
    if0.b = 5'(b);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    if0.in_valid = 1'b0; if0.op = '0; if0.a = '0; if0.b = '0;
    if0.out_ready = 1'b1; if0.err_clr = 1'b0;
    cyc(); cyc();
    tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", if0.out_valid); end
    tests++; if (if0.c !== 6'd0) begin fails++; $display("FAIL reset_c got %0d exp 0", if0.c); end
    tests++; if ({if0.error, if0.overflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {if0.error, if0.overflow}); end
    tests++; if (if0.err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got %0d exp 0", if0.err_count); end
    rst = 1'b0;
    cyc();
    tests++; if (if0.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", if0.in_ready); end
  endtask
  task automatic test_add();
    drive(4'd0, 7, 8);
    cyc();
    if0.in_valid = 1'b0;
    tests++; if (if0.out_valid !== 1'b1) begin fails++; $display("FAIL add_latency out_valid got %b exp 1", if0.out_valid); end
    tests++; if (if0.c !== 6'sd15 || if0.error !== 1'b0) begin fails++; $display("FAIL add c=%0d err=%b exp c=15 err=0", if0.c, if0.error); end
    cyc();
    tests++; if (if0.out_valid !== 1'b0) begin fails++; $display("FAIL add_release out_valid got %b exp 0", if0.out_valid); end
  endtask
  task automatic test_back_to_back();
    logic [3:0] ops [12] = '{4'd1, 4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    int as [12] = '{-5, 15, -15, 5, -1, 6, -2, 4, 5, 6, 0, 3};
    int bs [12] = '{7, 15, 15, 3, 3, 3, 7, 1, 3, 3, 9, 15};
    int ex [12] = '{-12, 30, -30, 6, -4, 2, 6, 5, -7, -3, -1, 17};
    for (int i = 0; i < 12; i++) begin
      drive(ops[i], as[i], bs[i]);
      #1;
      tests++; if (if0.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, if0.in_ready); end
      cyc();
      tests++; if (if0.out_valid !== 1'b1 || if0.c !== 6'(ex[i]) || if0.error !== 1'b0) begin fails++; $display("FAIL b2b[%0d] op=%0d v=%b c=%0d err=%b exp v=1 c=%0d err=0", i, ops[i], if0.out_valid, if0.c, if0.error, ex[i]); end
    end
    if0.in_valid = 1'b0;
    cyc();
  endtask
  task automatic test_mul();
    int as [4] = '{15, -3, -7, -8};
    int bs [4] = '{15, 5, -6, 5};
    int e0 [4] = '{-31, -15, -22, 24};
    int e1 [4] = '{31, -15, 31, -32};
    logic ov [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int n;
    for (int i = 0; i < 4; i++) begin
      drive(4'd9, as[i], bs[i]);
      cyc();
      if0.in_valid = 1'b0;
      tests++; if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b0) begin fails++; $display("FAIL mul_busy[%0d] in_ready=%b out_valid=%b exp 0 0", i, if0.in_ready, if0.out_valid); end
      n = 1;
      while (!if0.out_valid && n < 20) begin cyc(); n++; end
      tests++; if (n != 6) begin fails++; $display("FAIL mul_latency[%0d] got %0d exp 6", i, n); end
      tests++; if (if0.c !== 6'(e0[i]) || if0.overflow !== ov[i] || if0.error !== 1'b0) begin fails++; $display("FAIL mul_wrap[%0d] c=%0d ovf=%b err=%b exp c=%0d ovf=%b err=0", i, if0.c, if0.overflow, if0.error, e0[i], ov[i]); end
      tests++; if (if1.c !== 6'(e1[i]) || if1.overflow !== ov[i]) begin fails++; $display("FAIL mul_sat[%0d] c=%0d ovf=%b exp c=%0d ovf=%b", i, if1.c, if1.overflow, e1[i], ov[i]); end
      cyc();
    end
  endtask
  task automatic test_error();
    drive(4'd0, 3, 4);
    cyc();
    tests++; if (if0.c !== 6'sd7 || if0.error !== 1'b0) begin fails++; $display("FAIL err_pre c=%0d err=%b exp c=7 err=0", if0.c, if0.error); end
    drive(4'd12, 3, 4);
    cyc();
    tests++; if (if0.c !== 6'sd7 || if0.error !== 1'b1 || if0.err_count !== 8'd1) begin fails++; $display("FAIL err_illegal c=%0d err=%b cnt=%0d exp c=7 err=1 cnt=1", if0.c, if0.error, if0.err_count); end
    drive(4'd0, -16, 1);
    cyc();
    tests++; if (if0.c !== -6'sd15 || if0.error !== 1'b1 || if0.err_count !== 8'd2) begin fails++; $display("FAIL err_mostneg c=%0d err=%b cnt=%0d exp c=-15 err=1 cnt=2", if0.c, if0.error, if0.err_count); end
    if0.in_valid = 1'b0;
    cyc();
  endtask
  task automatic test_backpressure();
    if0.out_ready = 1'b0;
    drive(4'd0, 5, 6);
    cyc();
    drive(4'd1, 9, 2);
    for (int i = 0; i < 3; i++) begin
      tests++; if (if0.out_valid !== 1'b1 || if0.c !== 6'sd11 || if0.in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall[%0d] v=%b c=%0d rdy=%b exp v=1 c=11 rdy=0", i, if0.out_valid, if0.c, if0.in_ready); end
      cyc();
    end
    if0.out_ready = 1'b1;
    #1;
    tests++; if (if0.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release in_ready got %b exp 1", if0.in_ready); end
    cyc();
    if0.in_valid = 1'b0;
    tests++; if (if0.out_valid !== 1'b1 || if0.c !== 6'sd7) begin fails++; $display("FAIL bp_accept v=%b c=%0d exp v=1 c=7", if0.out_valid, if0.c); end
    cyc();
  endtask
  task automatic test_reset_mid_mul();
    int n;
    drive(4'd9, 15, 15);
    cyc();
    if0.in_valid = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    tests++; if (if0.out_valid !== 1'b0 || if0.c !== 6'd0 || if0.error !== 1'b0 || if0.overflow !== 1'b0 || if0.err_count !== 8'd0) begin fails++; $display("FAIL rst_mul v=%b c=%0d err=%b ovf=%b cnt=%0d exp all 0", if0.out_valid, if0.c, if0.error, if0.overflow, if0.err_count); end
    cyc();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin cyc(); if (if0.out_valid) n++; end
    tests++; if (n != 0 || if0.in_ready !== 1'b1) begin fails++; $display("FAIL rst_mul_abort valid_cycles=%0d rdy=%b exp 0 1", n, if0.in_ready); end
    drive(4'd0, 2, 3);
    cyc();
    if0.in_valid = 1'b0;
    tests++; if (if0.out_valid !== 1'b1 || if0.c !== 6'sd5) begin fails++; $display("FAIL rst_mul_after v=%b c=%0d exp v=1 c=5", if0.out_valid, if0.c); end
    cyc();
  endtask
  task automatic test_err_clr();
    drive(4'd15, 1, 1);
    cyc();
    drive(4'd13, 1, 1);
    cyc();
    tests++; if (if0.err_count !== 8'd2) begin fails++; $display("FAIL clr_pre cnt=%0d exp 2", if0.err_count); end
    drive(4'd0, -16, 0);
    if0.err_clr = 1'b1;
    cyc();
    tests++; if (if0.err_count !== 8'd1 || if0.c !== -6'sd16 || if0.error !== 1'b1) begin fails++; $display("FAIL clr_with_inc cnt=%0d c=%0d err=%b exp cnt=1 c=-16 err=1", if0.err_count, if0.c, if0.error); end
    if0.in_valid = 1'b0;
    cyc();
    if0.err_clr = 1'b0;
    tests++; if (if0.err_count !== 8'd0) begin fails++; $display("FAIL clr_alone cnt=%0d exp 0", if0.err_count); end
  endtask
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_error();
    test_backpressure();
    test_reset_mid_mul();
    test_err_clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
